// File: rtl/tqvp_intercal_alu_seq.sv
// rtl/tqvp_intercal_alu_seq.sv - multi-cycle INTERCAL ALU peripheral (mingle, select, unary ops)
// Operands are snapshotted at launch; select runs bit-serially and stalls RESULT reads.
module tqvp_intercal_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sa_q, sb_q, r_q;
  logic [WIDTH-1:0] a_d, b_d, comb_r, rot;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic             done_q, err_q;
  logic [31:0]      wmask, rmask, rdata;
  logic             busy, wr_en, wr_a, wr_b, wr_ctrl;
  logic             unused_ok;

  assign busy    = (state_q == ST_RUN);
  assign wr_en   = (data_write_n != 2'b11);
  assign wr_a    = wr_en && (address == 6'h00);
  assign wr_b    = wr_en && (address == 6'h04);
  assign wr_ctrl = wr_en && (address == 6'h08);

  always_comb begin
    wmask = 32'h0;
    case (data_write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      2'b10:   wmask = 32'hFFFF_FFFF;
      default: wmask = 32'h0;
    endcase
  end

  // Only the written lanes change; anything above WIDTH is dropped by the slice.
  assign a_d = (a_q & ~wmask[WIDTH-1:0]) | (data_in[WIDTH-1:0] & wmask[WIDTH-1:0]);
  assign b_d = (b_q & ~wmask[WIDTH-1:0]) | (data_in[WIDTH-1:0] & wmask[WIDTH-1:0]);
  assign rot = {sa_q[0], sa_q[WIDTH-1:1]};

  always_comb begin
    comb_r = '0;
    case (op_q)
      3'd0: begin
        for (int i = 0; i < WIDTH / 2; i++) begin
          comb_r[2*i+1] = sa_q[i];
          comb_r[2*i]   = sb_q[i];
        end
      end
      3'd2:    comb_r = sa_q & rot;
      3'd3:    comb_r = sa_q | rot;
      3'd4:    comb_r = sa_q ^ rot;
      default: comb_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (wr_a) a_q <= a_d;
      if (wr_b) b_q <= b_d;
      if (wr_ctrl) begin
        if (state_q == ST_IDLE) begin
          op_q    <= data_in[2:0];
          sa_q    <= a_q;
          sb_q    <= b_q;
          r_q     <= '0;
          cnt_q   <= CW'(WIDTH - 1);
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_RUN;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state_q == ST_RUN) begin
        if (op_q == 3'd1) begin
          // MSB-first walk: earlier selected bits end up higher in r.
          if (sb_q[cnt_q]) r_q <= {r_q[WIDTH-2:0], sa_q[cnt_q]};
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end else begin
          r_q     <= comb_r;
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (address)
      6'h00: rdata[WIDTH-1:0] = a_q;
      6'h04: rdata[WIDTH-1:0] = b_q;
      6'h08: begin
        rdata[2:0] = op_q;
        rdata[8]   = busy;
        rdata[9]   = done_q;
        rdata[10]  = err_q;
      end
      6'h0C: rdata[WIDTH-1:0] = r_q;
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    rmask = 32'hFFFF_FFFF;
    case (data_read_n)
      2'b00:   rmask = 32'h0000_00FF;
      2'b01:   rmask = 32'h0000_FFFF;
      default: rmask = 32'hFFFF_FFFF;
    endcase
  end

  assign data_out   = rdata & rmask;
  assign data_ready = !((address == 6'h0C) && (data_read_n != 2'b11) && busy);
  assign uo_out     = {6'b0, busy, 1'b0};
  assign unused_ok  = &{1'b0, ui_in, data_in};

endmodule

// File: tb/tb_tqvp_intercal_alu_seq.sv
// tb/tb_tqvp_intercal_alu_seq.sv - self-checking bench: WIDTH=32 and WIDTH=16 instances vs behavioural model
module tb_tqvp_intercal_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic [7:0]  ui_in = 8'h5A;
  logic [7:0]  uo_out  [2];
  logic [5:0]  addr    [2];
  logic [31:0] wdata   [2];
  logic [1:0]  wr_n    [2];
  logic [1:0]  rd_n    [2];
  logic [31:0] data_out[2];
  logic        data_ready[2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : dut_g
    tqvp_intercal_alu_seq #(.WIDTH(g == 0 ? 32 : 16)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .ui_in       (ui_in),
      .uo_out      (uo_out[g]),
      .address     (addr[g]),
      .data_in     (wdata[g]),
      .data_write_n(wr_n[g]),
      .data_read_n (rd_n[g]),
      .data_out    (data_out[g]),
      .data_ready  (data_ready[g])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      2'b10:   return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
    logic [31:0] r, rot, m;
    int j;
    r   = 32'h0;
    m   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    rot = ((a >> 1) | (a << (w - 1))) & m;
    j   = 0;
    case (op)
      3'd0: for (int i = 0; i < w / 2; i++) begin
              r[2*i+1] = a[i];
              r[2*i]   = b[i];
            end
      3'd1: for (int i = 0; i < w; i++) begin
              if (b[i]) begin
                r[j] = a[i];
                j++;
              end
            end
      3'd2: r = a & rot;
      3'd3: r = a | rot;
      3'd4: r = a ^ rot;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Behavioural model: registers as plain values, busy as a remaining-cycle count.
  for (genvar g = 0; g < 2; g++) begin : mdl_g
    localparam int          MW    = (g == 0) ? 32 : 16;
    localparam logic [31:0] MMASK = (g == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    logic [31:0] ma = 0, mb = 0, mres = 0, mfinal = 0;
    logic [2:0]  mop = 0;
    logic        mdone = 0, merr = 0;
    int          mleft = 0;

    initial forever begin
      @(posedge clk or negedge rst_n[g]);
      if (!rst_n[g]) begin
        ma = 0; mb = 0; mres = 0; mfinal = 0; mop = 0; mdone = 0; merr = 0; mleft = 0;
      end else begin
        automatic bit was_busy = (mleft > 0);
        automatic logic [31:0] m = size_mask(wr_n[g]);
        if (was_busy) begin
          mleft--;
          if (mleft == 0) begin
            mres  = mfinal;
            mdone = 1;
          end
        end
        if (wr_n[g] != 2'b11) begin
          case (addr[g])
            6'h00: ma = ((ma & ~m) | (wdata[g] & m)) & MMASK;
            6'h04: mb = ((mb & ~m) | (wdata[g] & m)) & MMASK;
            6'h08: begin
              if (was_busy) merr = 1;
              else begin
                mop    = wdata[g][2:0];
                mfinal = ref_op(mop, ma, mb, MW);
                mres   = 0;
                mleft  = (mop == 3'd1) ? MW : 1;
                mdone  = 0;
                merr   = 0;
              end
            end
            default: ;
          endcase
        end
      end
    end

    initial forever begin
      @(negedge clk);
      begin
        automatic logic        eb  = (mleft > 0);
        automatic logic        erd = !((addr[g] == 6'h0C) && (rd_n[g] != 2'b11) && eb);
        automatic logic [31:0] ev  = 0;
        check($sformatf("d%0d uo_out", g), {24'h0, uo_out[g]}, {24'h0, 6'b0, eb, 1'b0});
        check($sformatf("d%0d data_ready", g), {31'h0, data_ready[g]}, {31'h0, erd});
        if (rd_n[g] != 2'b11 && erd) begin
          case (addr[g])
            6'h00:   ev = ma;
            6'h04:   ev = mb;
            6'h08:   ev = {21'h0, merr, mdone, eb, 5'h0, mop};
            6'h0C:   ev = mres;
            default: ev = 0;
          endcase
          if (rd_n[g] != 2'b10) ev = ev & size_mask(rd_n[g]);
          check($sformatf("d%0d data_out @%h", g, addr[g]), data_out[g], ev);
        end
      end
    end
  end

  task automatic wr(input int d, input logic [5:0] a, input logic [31:0] v,
                    input logic [1:0] sz = 2'b10);
    addr[d]  = a;
    wdata[d] = v;
    wr_n[d]  = sz;
    @(posedge clk); #2;
    wr_n[d] = 2'b11;
  endtask

  task automatic rd(input int d, input logic [5:0] a, input logic [1:0] sz,
                    output logic [31:0] v, output int stall);
    addr[d] = a;
    rd_n[d] = sz;
    stall   = 0;
    v       = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (data_ready[d]) begin
        v = data_out[d];
        break;
      end
      stall++;
    end
    @(posedge clk); #2;
    rd_n[d] = 2'b11;
  endtask

  task automatic wait_idle(input int d, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (uo_out[d][1]) n++;
      else break;
    end
    @(posedge clk); #2;
  endtask

  task automatic rand_ops(input int d, input int n);
    logic [5:0]  atab [6] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h3F};
    logic [31:0] v;
    int          st;
    for (int k = 0; k < n; k++) begin
      automatic int          sel = $urandom_range(0, 9);
      automatic logic [5:0]  a   = atab[$urandom_range(0, 5)];
      automatic logic [1:0]  sz  = 2'($urandom_range(0, 2));
      if (sel < 5) begin
        if (sel < 2) a = 6'h08;
        wr(d, a, $urandom, sz);
      end else if (sel < 9) begin
        rd(d, a, sz, v, st);
        check($sformatf("d%0d rand read bound", d), {31'h0, st < 200}, 32'h1);
      end else begin
        @(posedge clk); #2;
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    int          st, n;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; addr[d] = 0; wdata[d] = 0; wr_n[d] = 2'b11; rd_n[d] = 2'b11;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    check("reset uo_out", {24'h0, uo_out[0]}, 32'h0);
    check("reset data_ready", {31'h0, data_ready[0]}, 32'h1);
    rd(0, 6'h08, 2'b10, v, st); check("reset CTRL", v, 32'h0);
    rd(0, 6'h0C, 2'b10, v, st); check("reset RESULT", v, 32'h0);
    rd(0, 6'h00, 2'b10, v, st); check("reset A", v, 32'h0);

    wr(0, 6'h00, 32'h0000_FFFF); wr(0, 6'h04, 32'h0); wr(0, 6'h08, 32'h0);
    wait_idle(0, n); check("mingle busy cycles", n, 32'd1);
    rd(0, 6'h0C, 2'b10, v, st); check("mingle result", v, 32'hAAAA_AAAA);
    rd(0, 6'h08, 2'b10, v, st); check("mingle CTRL", v, 32'h0000_0200);

    wr(0, 6'h00, 32'h1234_5678); wr(0, 6'h04, 32'hFF00_FF00); wr(0, 6'h08, 32'h1);
    rd(0, 6'h0C, 2'b10, v, st);
    check("select stall", st, 32'd32);
    check("select result", v, 32'h0000_1256);

    wr(0, 6'h00, 32'h3); wr(0, 6'h08, 32'h2); wait_idle(0, n);
    rd(0, 6'h0C, 2'b10, v, st); check("unary AND", v, 32'h1);
    wr(0, 6'h00, 32'h1); wr(0, 6'h08, 32'h3); wait_idle(0, n);
    rd(0, 6'h0C, 2'b10, v, st); check("unary OR", v, 32'h8000_0001);
    wr(0, 6'h00, 32'hFFFF_FFFF); wr(0, 6'h08, 32'h4); wait_idle(0, n);
    rd(0, 6'h0C, 2'b10, v, st); check("unary XOR", v, 32'h0);
    wr(0, 6'h08, 32'h6); wait_idle(0, n);
    rd(0, 6'h0C, 2'b10, v, st); check("op6", v, 32'h0);

    wr(0, 6'h00, 32'h12); wr(0, 6'h00, 32'h56, 2'b00);
    rd(0, 6'h00, 2'b01, v, st); check("byte lane A", v, 32'h0000_0056);

    wr(0, 6'h00, 32'h1234_5678); wr(0, 6'h08, 32'h1);
    wr(0, 6'h08, 32'h2); wr(0, 6'h00, 32'hABCD_EF01);
    wait_idle(0, n);
    rd(0, 6'h08, 2'b10, v, st); check("inflight CTRL err", v, 32'h0000_0601);
    rd(0, 6'h0C, 2'b10, v, st); check("inflight result", v, 32'h0000_1256);
    wr(0, 6'h08, 32'h1); wait_idle(0, n);
    rd(0, 6'h08, 2'b10, v, st); check("relaunch CTRL", v, 32'h0000_0201);
    rd(0, 6'h0C, 2'b10, v, st); check("relaunch result", v, 32'h0000_ABEF);

    wr(0, 6'h08, 32'h1);
    addr[0] = 6'h0C; rd_n[0] = 2'b10;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("stall before reset", {31'h0, data_ready[0]}, 32'h0);
    @(posedge clk); #2;
    rst_n[0] = 1'b0;
    #1;
    check("async reset ready", {31'h0, data_ready[0]}, 32'h1);
    check("async reset uo_out", {24'h0, uo_out[0]}, 32'h0);
    check("async reset RESULT", data_out[0], 32'h0);
    addr[0] = 6'h08; #1;
    check("async reset CTRL", data_out[0], 32'h0);
    rd_n[0] = 2'b11;
    @(posedge clk); #2;
    rst_n[0] = 1'b1;
    rd(0, 6'h0C, 2'b10, v, st); check("post reset RESULT", v, 32'h0);
    rd(0, 6'h00, 2'b10, v, st); check("post reset A", v, 32'h0);

    wr(1, 6'h00, 32'hFFFF_00FF); wr(1, 6'h04, 32'h0); wr(1, 6'h08, 32'h0);
    wait_idle(1, n); check("w16 mingle busy", n, 32'd1);
    rd(1, 6'h0C, 2'b10, v, st); check("w16 mingle", v, 32'h0000_AAAA);
    wr(1, 6'h04, 32'h0000_FFFF, 2'b01); wr(1, 6'h08, 32'h1);
    rd(1, 6'h0C, 2'b10, v, st);
    check("w16 select stall", st, 32'd16);
    check("w16 select", v, 32'h0000_00FF);

    rand_ops(0, 300);
    rand_ops(1, 300);
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
